// File: rtl/comparer_pkg.sv
// Shared types and sizing helpers for the multi-cycle operand comparer.
package comparer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned num_digits(input int unsigned width,
                                              input int unsigned digit);
      return width / digit;
   endfunction

   // Index counter width; a single-digit scan still needs a 1-bit counter.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational equality and unsigned less-than for one DIGIT-bit slice.
module digit_compare #(
   parameter int unsigned DIGIT = 8
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   output logic             o_eq_c,
   output logic             o_lt_c
);

   assign o_eq_c = (i_a == i_b);
   assign o_lt_c = (i_a <  i_b);

endmodule

// File: rtl/comparer_multicycle.sv
// MSB-first digit-serial comparer producing eq / signed lt / unsigned lt
// between the operand read stage and branch/SLT writeback.
module comparer_multicycle
   import comparer_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eql,
   output logic             slt,
   output logic             sltu
);

   localparam int unsigned     N        = num_digits(WIDTH, DIGIT);
   localparam int unsigned     IDX_W    = idx_width(N);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             r_eql;
   logic             r_slt;
   logic             r_sltu;
   logic             w_eql_nxt;
   logic             w_slt_nxt;
   logic             w_sltu_nxt;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [DIGIT-1:0] w_dig_a;
   logic [DIGIT-1:0] w_dig_b;
   logic             w_dig_eq;
   logic             w_dig_lt;
   logic             w_accept;
   logic             w_sign_diff;

   // Select the digit currently under scan from the captured operands.
   assign w_a_sh      = r_a >> (DIGIT * 32'(r_idx));
   assign w_b_sh      = r_b >> (DIGIT * 32'(r_idx));
   assign w_dig_a     = w_a_sh[DIGIT-1:0];
   assign w_dig_b     = w_b_sh[DIGIT-1:0];
   assign w_accept    = in_valid & r_in_ready;
   assign w_sign_diff = r_a[WIDTH-1] ^ r_b[WIDTH-1];

   digit_compare #(
      .DIGIT (DIGIT)
   ) u_digit_compare (
      .i_a    (w_dig_a),
      .i_b    (w_dig_b),
      .o_eq_c (w_dig_eq),
      .o_lt_c (w_dig_lt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_idx_nxt   = r_idx;
      w_eql_nxt   = r_eql;
      w_slt_nxt   = r_slt;
      w_sltu_nxt  = r_sltu;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_a_nxt     = a;
               w_b_nxt     = b;
               w_idx_nxt   = IDX_LAST;
               w_eql_nxt   = 1'b0;
               w_slt_nxt   = 1'b0;
               w_sltu_nxt  = 1'b0;
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (!w_dig_eq) begin
               // First differing digit decides; opposite signs override magnitude.
               w_sltu_nxt  = w_dig_lt;
               w_slt_nxt   = w_sign_diff ? r_a[WIDTH-1] : w_dig_lt;
               w_eql_nxt   = 1'b0;
               w_state_nxt = DONE;
            end else if (r_idx == '0) begin
               w_eql_nxt   = 1'b1;
               w_slt_nxt   = 1'b0;
               w_sltu_nxt  = 1'b0;
               w_state_nxt = DONE;
            end else begin
               w_idx_nxt   = r_idx - IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and handshake registers; ready/valid follow the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= IDX_LAST;
         r_eql       <= 1'b0;
         r_slt       <= 1'b0;
         r_sltu      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_idx       <= w_idx_nxt;
         r_eql       <= w_eql_nxt;
         r_slt       <= w_slt_nxt;
         r_sltu      <= w_sltu_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign eql       = r_eql;
   assign slt       = r_slt;
   assign sltu      = r_sltu;

endmodule

// File: tb/tb_comparer_multicycle.sv
// Self-checking bench for comparer_multicycle (WIDTH=32, DIGIT=8).
module tb_comparer_multicycle;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 8;
   localparam int unsigned ND = W / D;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic          out_valid;
   logic          out_ready;
   logic          eql;
   logic          slt;
   logic          sltu;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   comparer_multicycle #(
      .WIDTH (W),
      .DIGIT (D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eql       (eql),
      .slt       (slt),
      .sltu      (sltu)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        e;
      logic        s;
      logic        u;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input int tag,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h want %h", nm, tag, act, exp);
      end
   endtask

   // Reference: compare as integers; latency = leading equal digits + 1, capped at ND.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic e, output logic s, output logic u,
                                 output int lat);
      int j;
      bit stop;
      logic [31:0] dx, dy;
      j    = 0;
      stop = 1'b0;
      e = (x == y);
      s = ($signed(x) < $signed(y));
      u = (x < y);
      for (int k = ND - 1; k >= 0; k--) begin
         dx = (x >> (D * k)) & 32'hFF;
         dy = (y >> (D * k)) & 32'hFF;
         if (!stop && dx == dy) j++;
         else stop = 1'b1;
      end
      lat = (j == ND) ? ND : j + 1;
   endfunction

   task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                         input logic e, input logic s, input logic u,
                         input int lat, input int tag, input int hold);
      int n;
      int waitc;
      waitc = 0;
      while (!in_ready && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("in_ready_pre", tag, 32'(in_ready), 32'd1);
      a_i = x; b_i = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_i = $urandom; b_i = $urandom;
      chk("in_ready_busy", tag, 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < int'(ND) + 4) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", tag, n, lat);
      chk("eql", tag, 32'(eql), 32'(e));
      chk("slt", tag, 32'(slt), 32'(s));
      chk("sltu", tag, 32'(sltu), 32'(u));
      repeat (hold) begin
         @(posedge clk); #1;
         chk("hold_valid", tag, 32'(out_valid), 32'd1);
         chk("hold_res", tag, 32'({eql, slt, sltu}), 32'({e, s, u}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", tag, 32'(out_valid), 32'd0);
      chk("ready_back", tag, 32'(in_ready), 32'd1);
   endtask

   vec_t vecs[12];

   initial begin
      logic e, s, u;
      int   lat;
      logic [31:0] x, y;

      vecs[0]  = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 4};
      vecs[1]  = '{32'h01000000, 32'h02000000, 1'b0, 1'b1, 1'b1, 1};
      vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 1};
      vecs[3]  = '{32'h12345600, 32'h123456FF, 1'b0, 1'b1, 1'b1, 4};
      vecs[4]  = '{32'h123456FF, 32'h12345600, 1'b0, 1'b0, 1'b0, 4};
      vecs[5]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[6]  = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
      vecs[7]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 4};
      vecs[8]  = '{32'h00010000, 32'h00000000, 1'b0, 1'b0, 1'b0, 2};
      vecs[9]  = '{32'hFFFFFF00, 32'hFFFFFF01, 1'b0, 1'b1, 1'b1, 4};
      vecs[10] = '{32'h12FF0000, 32'h12000000, 1'b0, 1'b0, 1'b0, 2};
      vecs[11] = '{32'h8000FF00, 32'h80010000, 1'b0, 1'b1, 1'b1, 2};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
      chk("rst_outs", 0, 32'({out_valid, eql, slt, sltu}), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_release_ready", 0, 32'(in_ready), 32'd1);

      for (int i = 0; i < 12; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].s, vecs[i].u,
                vecs[i].lat, i, i % 3);

      // Result held under backpressure; operands offered meanwhile must be ignored.
      a_i = 32'h01000000; b_i = 32'h02000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      begin
         int n;
         n = 0;
         while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         chk("bp_latency", 100, n, 1);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         a_i = 32'h12345678; b_i = 32'h12345678;
         @(posedge clk); #1;
         chk("bp_valid", 100 + c, 32'(out_valid), 32'd1);
         chk("bp_ready", 100 + c, 32'(in_ready), 32'd0);
         chk("bp_res", 100 + c, 32'({eql, slt, sltu}), 32'b011);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_ready_after", 100, 32'(in_ready), 32'd1);
      chk("bp_valid_after", 100, 32'(out_valid), 32'd0);
      for (int c = 0; c < int'(ND) + 2; c++) begin
         @(posedge clk); #1;
         chk("bp_no_ghost", 110 + c, 32'(out_valid), 32'd0);
      end

      // Reset on the second SCAN cycle discards the operation.
      a_i = 32'hAAAAAAAA; b_i = 32'hAAAAAAAA; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_outs", 200, 32'({out_valid, eql, slt, sltu}), 32'd0);
      chk("mid_rst_ready", 200, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_ready_after", 200, 32'(in_ready), 32'd1);
      for (int c = 0; c < int'(ND) + 2; c++) begin
         chk("mid_rst_no_result", 210 + c, 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end

      // Random operands; half share a random number of leading digits.
      for (int i = 0; i < 40; i++) begin
         int keep;
         logic [31:0] mask;
         x = $urandom;
         y = $urandom;
         if (i % 2 == 0) begin
            keep = int'($urandom_range(0, ND));
            mask = (keep == int'(ND)) ? 32'hFFFFFFFF
                                      : ~(32'hFFFFFFFF >> (D * keep));
            y = (x & mask) | (y & ~mask);
         end
         model(x, y, e, s, u, lat);
         run_op(x, y, e, s, u, lat, 300 + i, int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/comparer_multicycle.md
# comparer_multicycle

Parametrised multi-cycle successor to the single-bit flag comparer in the ALU compare path. It accepts two WIDTH-bit operands over a valid/ready handshake and scans them MSB-first, DIGIT bits per cycle, stopping at the first differing digit. It returns registered equal, signed less-than and unsigned less-than results over a second valid/ready handshake. It sits between the operand register file read stage and the branch/SLT writeback logic.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  rising-edge clock; the block uses one clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- out_valid  output  1  results are valid and held.
- out_ready  input  1  consumer accepts the results.
- eql  output  1  a == b.
- slt  output  1  a < b, two's-complement.
- sltu  output  1  a < b, unsigned.

## Operation
- N = WIDTH/DIGIT digits. Digit k is bits [k·DIGIT+DIGIT-1 : k·DIGIT]. The scan starts at k = N-1.
- The state machine has three states: IDLE, SCAN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid, a and b are captured into internal registers, idx = N-1, and the state moves to SCAN.
  - eql, slt and sltu clear to 0 on capture.
- **SCAN**
  - Each cycle compares captured digit idx of a against digit idx of b.
  - If the digits differ:
    - sltu = (digit_a < digit_b).
    - slt = a[WIDTH-1] when a[WIDTH-1] != b[WIDTH-1]; otherwise slt = sltu.
    - eql = 0. The state moves to DONE.
  - If the digits are equal and idx == 0: eql = 1, slt = 0, sltu = 0. The state moves to DONE.
  - If the digits are equal and idx > 0: idx decrements and the state stays in SCAN.
- **DONE**
  - out_valid = 1, and results are held stable.
  - On out_ready the state returns to IDLE, and out_valid drops the next cycle.
- in_valid is ignored outside IDLE. Operand inputs are only sampled on the accept edge.
- eql, slt and sltu are registered. They change only on the decision edge or on a new accept.

## Timing
- Reset values: in_ready = 0 while reset is asserted and 1 the cycle after. out_valid = 0, eql = 0, slt = 0, sltu = 0. State = IDLE, idx = N-1.
- Accept edge E0 occurs when in_valid & in_ready.
- If j leading digits are equal (0 ≤ j < N), out_valid rises after edge E0 + j + 1.
- If all digits are equal, out_valid rises after E0 + N.
- Minimum latency is 1 cycle; maximum is N cycles (4 with the defaults).
- Result handshake edge: out_valid & out_ready. in_ready rises the following cycle, so one bubble separates operations. Throughput for equal operands is 1 per N+2 cycles.
- out_ready held low: the block stays in DONE indefinitely with outputs frozen.
- Reset during SCAN or DONE: the in-flight operation is discarded, with no out_valid. Reset values apply from the next cycle.
- DIGIT == WIDTH: the decision is always made on the first SCAN edge.

## Structure
- Package comparer_pkg holds the state encodings (IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2) and the digit-count function N = WIDTH/DIGIT.
- Sub-module digit_compare, parametrised by DIGIT, is purely combinational. It takes two DIGIT-bit inputs and produces eq and lt (unsigned). It is instantiated once and fed through an idx-driven mux of the captured operands.
- The top level holds the FSM, the operand registers, the idx counter (width clog2(N), minimum 1) and the result registers.

## Test plan
All scenarios use WIDTH = 32 and DIGIT = 8.
1. a = b = 0x12345678 → out_valid 4 cycles after accept; eql = 1, slt = 0, sltu = 0.
2. a = 0x01000000, b = 0x02000000 → out_valid 1 cycle after accept; eql = 0, slt = 1, sltu = 1.
3. a = 0xFFFFFFFF, b = 0x00000001 → 1 cycle; slt = 1, sltu = 0, eql = 0.
4. a = 0x12345600, b = 0x123456FF → 4 cycles; sltu = 1, slt = 1. Then swap the operands → sltu = 0, slt = 0.
5. Hold out_ready = 0 for 5 cycles after out_valid, while pulsing in_valid with new operands → outputs stay frozen, in_ready = 0, and the new operands are not captured. After out_ready = 1 for one cycle, in_ready = 1 the cycle after.
6. a = b = 0xAAAAAAAA; assert reset at the 2nd SCAN cycle → the next cycle shows out_valid = 0, eql = slt = sltu = 0, in_ready = 1 after reset deasserts, and no result is emitted.
